// File: rtl/mul4_shift_add_ctrl_if.sv
// Bundle of the multiplier's request/result handshake and its external adder bus.
// slave is the controller side; master is whoever issues requests and hosts the adder.
interface mul4_shift_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_cin;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;

  modport slave (
    input  start, multiplicand, multiplier, add_sum, add_cout,
    output product, busy, done, add_a, add_b, add_cin
  );

  modport master (
    output start, multiplicand, multiplier, add_sum, add_cout,
    input  product, busy, done, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mul4_shift_add_ctrl.sv
// Sequential unsigned shift-add multiplier: one partial product per clock through an
// external combinational adder, with a start/busy/done handshake.
module mul4_shift_add_ctrl #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  mul4_shift_add_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     m;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   shifted;

  // Partial sum (with adder carry) shifted right by one into the {acc,q} pair.
  assign shifted = {bus.add_cout, bus.add_sum, q[WIDTH-1:1]};

  function automatic logic [WIDTH-1:0] sel_addend(input logic q_lsb,
                                                  input logic [WIDTH-1:0] mcand);
    return q_lsb ? mcand : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Adder is only driven while iterating; otherwise held at zero.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state == CALC) begin
      bus.add_a = acc;
      bus.add_b = sel_addend(q[0], m);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= bus.multiplicand;
            q   <= bus.multiplier;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          {acc, q} <= shifted;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) product_r <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_r;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_mul4_shift_add_ctrl.sv
// Directed bench for mul4_shift_add_ctrl with a 4-bit carry-lookahead adder model on the adder bus.
module tb_mul4_shift_add_ctrl;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   last_accept = 0;

  always #5 clk = ~clk;

  mul4_shift_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul4_shift_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 4-bit carry-lookahead adder
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = bus.add_a ^ bus.add_b;
  assign g = bus.add_a & bus.add_b;
  assign c[0] = bus.add_cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign bus.add_sum  = p ^ c[3:0];
  assign bus.add_cout = c[4];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_mul(input logic [3:0] mv, input logic [3:0] qv, input bit chk_space,
                         input bit verbose);
    int n;
    int d0;
    logic [7:0] exp_p;
    exp_p = 8'(mv) * 8'(qv);
    d0 = done_seen;
    bus.multiplicand = mv;
    bus.multiplier   = qv;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    if (chk_space) check("spacing", 32'(cyc - last_accept), 32'd6);
    last_accept = cyc;
    if (verbose) begin
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      check("done_after_accept", 32'(bus.done), 32'd0);
    end
    wait_done(n);
    if (verbose) check("latency", 32'(n), 32'(WIDTH));
    check("product", 32'(bus.product), 32'(exp_p));
    tick();
    if (verbose) begin
      check("busy_back_idle", 32'(bus.busy), 32'd0);
      check("done_pulses", 32'(done_seen - d0), 32'd1);
    end
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_product", 32'(bus.product), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_add_a", 32'(bus.add_a), 32'd0);
    check("rst_add_b", 32'(bus.add_b), 32'd0);
    check("rst_add_cin", 32'(bus.add_cin), 32'd0);

    run_mul(4'd15, 4'd15, 1'b0, 1'b1);
    run_mul(4'd5, 4'd3, 1'b0, 1'b1);
    run_mul(4'd0, 4'd9, 1'b0, 1'b1);
    run_mul(4'd9, 4'd0, 1'b0, 1'b1);

    // Start held high through CALC with operands changing underneath.
    d0 = done_seen;
    bus.multiplicand = 4'd7;
    bus.multiplier   = 4'd6;
    bus.start        = 1'b1;
    tick();
    bus.multiplicand = 4'd15;
    bus.multiplier   = 4'd15;
    check("calc_cin", 32'(bus.add_cin), 32'd0);
    wait_done(n);
    bus.start = 1'b0;
    check("held_latency", 32'(n), 32'(WIDTH));
    check("held_product", 32'(bus.product), 32'h2A);
    tick();
    tick();
    check("held_done_pulses", 32'(done_seen - d0), 32'd1);
    check("held_busy", 32'(bus.busy), 32'd0);

    // Reset in the second CALC cycle discards the job.
    d0 = done_seen;
    bus.multiplicand = 4'd12;
    bus.multiplier   = 4'd11;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_product", 32'(bus.product), 32'h00);
    check("abort_add_a", 32'(bus.add_a), 32'd0);
    repeat (6) tick();
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    check("abort_product_hold", 32'(bus.product), 32'h00);
    run_mul(4'd3, 4'd4, 1'b0, 1'b1);

    // Exhaustive, back-to-back at minimum spacing.
    d0 = done_seen;
    for (int i = 0; i < 256; i++) begin
      run_mul(4'(i >> 4), 4'(i), (i != 0), 1'b0);
    end
    check("exh_done_pulses", 32'(done_seen - d0), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
